pcspma_frame_checker: RTL and testbench
=======================================

# pcspma_frame_checker

Receive-side checker for the SFP PCS/PMA test path. It sits on the GMII receive interface of one PCS/PMA channel and checks the test frames sent by the matching frame generator at the far end of the link. Each frame is checked for preamble/SFD, header, length, payload pattern, CRC-32 and sequence continuity. Outputs are frame-event pulses, saturating statistics counters and a link-OK indication used to drive the board status LEDs.

## Interface
- PAYLOAD_LEN, 46: payload bytes per test frame; legal range 46..1500.
- LOCK_FRAMES, 4: consecutive good frames required to assert link_ok; legal range 1..255.
- TIMEOUT_CYCLES, 12_500_000: idle cycles with no frame before link_ok drops (100 ms at 125 MHz).
- userclk  in  1  125 MHz PCS/PMA user clock; all logic on rising edge.
- sys_reset_n  in  1  reset, asynchronous and active-low.
- gmii_rxd  in  8  GMII receive data.
- gmii_rx_dv  in  1  GMII receive data valid.
- gmii_rx_er  in  1  GMII receive error.
- frame_ok  out  1  one-cycle pulse: frame passed all checks.
- frame_bad  out  1  one-cycle pulse: frame failed any format/length/CRC/rx_er check.
- seq_err  out  1  one-cycle pulse: good frame with an unexpected sequence number.
- good_cnt  out  32  good frames, saturating.
- bad_cnt  out  32  bad frames, saturating.
- seq_err_cnt  out  32  sequence errors, saturating.
- link_ok  out  1  level: link carrying valid test traffic.

## Operation
- Frame format: 1..7 × 0x55, 0xD5, DA = FF:FF:FF:FF:FF:FF, SA (any), EtherType 0x88B5, SEQ (32 b, MSB first), payload byte i = (SEQ[7:0] + i) mod 256, FCS (4 B).
- Checked length N = 18 + 4 + PAYLOAD_LEN bytes (DA through FCS).
- States: IDLE, PRE, HDR, SEQ, PAY, FCS, DROP.
- IDLE: rx_dv=1 and rxd=0x55 → PRE. Any other byte → DROP, marked bad.
- PRE: 0x55 stays in PRE up to 7 total. 0xD5 → HDR. An 8th 0x55 or any other byte → DROP, bad.
- HDR → SEQ → PAY → FCS advance on a byte counter. A wrong DA/EtherType/payload byte marks the frame bad; the state still advances.
- After byte N: rx_dv still high → DROP, bad (too long). rx_dv low before byte N → bad (too short), back to IDLE.
- DROP: waits for rx_dv=0, then IDLE.
- rx_er with rx_dv=1 marks the frame bad. rx_er with rx_dv=0 is ignored.
- CRC: Ethernet CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF), byte-serial over DA..FCS. Pass when the residue equals 0xC704DD7B.
- Sequence: the expected value is held in a register. Each good frame compares SEQ with it; a mismatch pulses seq_err. Either way the register reloads with SEQ+1 (mod 2^32).
- Sequence resync: the first good frame after reset, or after link_ok falls, is never a sequence error.
- A frame with seq_err still counts in good_cnt.
- link_ok: a consecutive-good counter increments on frame_ok and clears on frame_bad or seq_err. It asserts when the counter reaches LOCK_FRAMES.
- link_ok clears on frame_bad, on seq_err, or after TIMEOUT_CYCLES cycles with rx_dv low.
- Counters stick at 0xFFFFFFFF.

## Timing
- Reset values: all outputs 0; state IDLE; expected sequence register invalid.
- The verdict is issued in the cycle after the first rx_dv=0 sample ending a frame. For DROP frames, that is the first rx_dv=0 cycle after DROP.
- In that verdict cycle: exactly one of frame_ok/frame_bad pulses. seq_err can only pulse together with frame_ok.
- Counters and link_ok update on the same edge as the pulses (registered, 1 cycle after the verdict decision).
- A minimum inter-frame gap of one rx_dv=0 cycle is supported. A new frame may start in the cycle the verdict pulses.
- The timeout counter resets on any rx_dv=1 and saturates at TIMEOUT_CYCLES.
- Asserting sys_reset_n low mid-frame aborts it immediately with no verdict. After release, the partial frame's remainder is treated as a new frame start (bad unless rxd=0x55).

## Configuration
- PCSPMA_CHK_SEQ_EN defined: sequence checking as described.
- PCSPMA_CHK_SEQ_EN undefined: no expected-sequence logic is built. seq_err and seq_err_cnt are tied to 0. SEQ bytes are still covered by the CRC and still seed the payload pattern.

## Test plan
- 10 good frames, SEQ 0..9, PAYLOAD_LEN=46, 12-cycle gaps → 10 frame_ok pulses, good_cnt=10, bad_cnt=0, link_ok high after the 4th verdict.
- Frame SEQ=10 with one FCS bit flipped → frame_bad, bad_cnt=1, link_ok low. The next 4 good frames reassert link_ok.
- Good frames SEQ 20, 21, 23 → seq_err pulses on the third frame, seq_err_cnt=1, good_cnt=3. Undefining PCSPMA_CHK_SEQ_EN gives seq_err_cnt=0.
- Frame with rx_er high for one payload cycle, then a frame 1 byte short, then a frame 1 byte long → bad_cnt=3, no frame_ok.
- Lock the link, then keep rx_dv low for TIMEOUT_CYCLES (overridden to 1000) → link_ok falls on cycle 1000. The next good frame with any SEQ gives no seq_err.
- Assert reset mid-payload → all outputs 0 immediately, no verdict pulse. Frames after release are checked normally.

Source files
------------

// File: rtl/pcspma_frame_checker.sv
`default_nettype none
// ============================================================================
// Module  : pcspma_frame_checker
// Brief   : GMII receive checker for PCS/PMA test frames (preamble, header,
//           length, payload pattern, CRC-32, sequence). Sequence checking is
//           built only when PCSPMA_CHK_SEQ_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module pcspma_frame_checker #(
    parameter int PAYLOAD_LEN    = 46,
    parameter int LOCK_FRAMES    = 4,
    parameter int TIMEOUT_CYCLES = 12_500_000
) (
    input  logic        userclk,
    input  logic        sys_reset_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic        frame_ok,
    output logic        frame_bad,
    output logic        seq_err,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt,
    output logic [31:0] seq_err_cnt,
    output logic        link_ok
);

    localparam logic [2:0]  c_st_idle = 3'd0;
    localparam logic [2:0]  c_st_pre  = 3'd1;
    localparam logic [2:0]  c_st_hdr  = 3'd2;
    localparam logic [2:0]  c_st_seq  = 3'd3;
    localparam logic [2:0]  c_st_pay  = 3'd4;
    localparam logic [2:0]  c_st_fcs  = 3'd5;
    localparam logic [2:0]  c_st_drop = 3'd6;

    localparam logic [15:0] c_n_bytes   = 16'(22 + PAYLOAD_LEN);
    localparam logic [15:0] c_pay_end   = 16'(17 + PAYLOAD_LEN);
    localparam logic [31:0] c_timeout   = 32'(TIMEOUT_CYCLES);
    localparam logic [7:0]  c_lock      = 8'(LOCK_FRAMES);
    localparam logic [31:0] c_crc_poly  = 32'hEDB88320;
    // Residue in MSB-first form; the shift register holds it bit-reversed.
    localparam logic [31:0] c_crc_residue = 32'hC704DD7B;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [2:0]  r_pre_cnt;
    logic [15:0] r_byte_cnt;
    logic        r_err;
    logic        w_err_nxt;
    logic        w_end;
    logic        w_data_byte;
    logic        w_byte_bad;
    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;
    logic [31:0] w_crc_rev;
    logic        w_crc_ok;
    logic [7:0]  r_pat;
    logic        w_good;
    logic        w_bad;
    logic        w_seq_mis;
    logic        w_timeout;
    logic        r_frame_ok;
    logic        r_frame_bad;
    logic [31:0] r_good_cnt;
    logic [31:0] r_bad_cnt;
    logic [31:0] r_idle_cnt;
    logic [7:0]  r_run;
    logic        r_link_ok;

    always_comb begin
        w_byte_bad = 1'b0;
        case (r_state)
            c_st_hdr: begin
                if (r_byte_cnt < 16'd6)        w_byte_bad = (gmii_rxd != 8'hFF);
                else if (r_byte_cnt == 16'd12) w_byte_bad = (gmii_rxd != 8'h88);
                else if (r_byte_cnt == 16'd13) w_byte_bad = (gmii_rxd != 8'hB5);
            end
            c_st_pay: w_byte_bad = (gmii_rxd != r_pat);
            default:  w_byte_bad = 1'b0;
        endcase
    end

    always_comb begin
        w_crc_nxt = r_crc ^ {24'h0, gmii_rxd};
        for (int k = 0; k < 8; k++) begin
            w_crc_nxt = w_crc_nxt[0] ? ((w_crc_nxt >> 1) ^ c_crc_poly) : (w_crc_nxt >> 1);
        end
        w_crc_rev = '0;
        for (int k = 0; k < 32; k++) begin
            w_crc_rev[k] = r_crc[31-k];
        end
    end

    assign w_crc_ok = (w_crc_rev == c_crc_residue);

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_end       = 1'b0;
        w_data_byte = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (gmii_rx_dv) begin
                    w_err_nxt   = gmii_rx_er | (gmii_rxd != 8'h55);
                    w_state_nxt = (gmii_rxd == 8'h55) ? c_st_pre : c_st_drop;
                end
            end
            c_st_pre: begin
                if (!gmii_rx_dv) begin
                    w_end       = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_err_nxt = r_err | gmii_rx_er;
                    if (gmii_rxd == 8'hD5) begin
                        w_state_nxt = c_st_hdr;
                    end else if (!(gmii_rxd == 8'h55 && r_pre_cnt != 3'd7)) begin
                        w_state_nxt = c_st_drop;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            c_st_hdr, c_st_seq, c_st_pay, c_st_fcs: begin
                if (!gmii_rx_dv) begin
                    w_end       = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (r_byte_cnt == c_n_bytes) begin
                    w_state_nxt = c_st_drop;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_data_byte = 1'b1;
                    w_err_nxt   = r_err | gmii_rx_er | w_byte_bad;
                    if (r_state == c_st_hdr && r_byte_cnt == 16'd13)
                        w_state_nxt = c_st_seq;
                    else if (r_state == c_st_seq && r_byte_cnt == 16'd17)
                        w_state_nxt = c_st_pay;
                    else if (r_state == c_st_pay && r_byte_cnt == c_pay_end)
                        w_state_nxt = c_st_fcs;
                end
            end
            c_st_drop: begin
                if (!gmii_rx_dv) begin
                    w_end       = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign w_good    = w_end && (r_state == c_st_fcs) && (r_byte_cnt == c_n_bytes) &&
                       !r_err && w_crc_ok;
    assign w_bad     = w_end && !w_good;
    assign w_timeout = !gmii_rx_dv && (r_idle_cnt >= c_timeout - 32'd1);

    always_ff @(posedge userclk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state    <= c_st_idle;
            r_pre_cnt  <= 3'd0;
            r_byte_cnt <= 16'd0;
            r_err      <= 1'b0;
            r_crc      <= 32'hFFFFFFFF;
            r_pat      <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (r_state == c_st_idle && gmii_rx_dv)
                r_pre_cnt <= 3'd1;
            else if (r_state == c_st_pre && gmii_rx_dv && gmii_rxd == 8'h55 && r_pre_cnt != 3'd7)
                r_pre_cnt <= r_pre_cnt + 3'd1;
            if (r_state == c_st_pre && w_state_nxt == c_st_hdr) begin
                r_byte_cnt <= 16'd0;
                r_crc      <= 32'hFFFFFFFF;
            end else if (w_data_byte) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
                r_crc      <= w_crc_nxt;
            end
            // The last SEQ byte seeds the payload pattern.
            if (w_data_byte && r_state == c_st_seq && r_byte_cnt == 16'd17)
                r_pat <= gmii_rxd;
            else if (w_data_byte && r_state == c_st_pay)
                r_pat <= r_pat + 8'd1;
        end
    end

`ifdef PCSPMA_CHK_SEQ_EN
    logic [31:0] r_seq_cap;
    logic [31:0] r_seq_exp;
    logic        r_seq_valid;
    logic        r_seq_err;
    logic [31:0] r_seq_err_cnt;

    assign w_seq_mis = w_good && r_seq_valid && (r_seq_cap != r_seq_exp);

    always_ff @(posedge userclk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_seq_cap     <= 32'd0;
            r_seq_exp     <= 32'd0;
            r_seq_valid   <= 1'b0;
            r_seq_err     <= 1'b0;
            r_seq_err_cnt <= 32'd0;
        end else begin
            if (w_data_byte && r_state == c_st_seq)
                r_seq_cap <= {r_seq_cap[23:0], gmii_rxd};
            if (w_good)
                r_seq_exp <= r_seq_cap + 32'd1;
            // Losing the link forces a resync on the next good frame.
            if (r_link_ok && (w_bad || w_seq_mis || w_timeout))
                r_seq_valid <= 1'b0;
            else if (w_good)
                r_seq_valid <= 1'b1;
            r_seq_err <= w_seq_mis;
            if (w_seq_mis && r_seq_err_cnt != 32'hFFFFFFFF)
                r_seq_err_cnt <= r_seq_err_cnt + 32'd1;
        end
    end

    assign seq_err     = r_seq_err;
    assign seq_err_cnt = r_seq_err_cnt;
`else
    assign w_seq_mis   = 1'b0;
    assign seq_err     = 1'b0;
    assign seq_err_cnt = 32'd0;
`endif

    always_ff @(posedge userclk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_frame_ok  <= 1'b0;
            r_frame_bad <= 1'b0;
            r_good_cnt  <= 32'd0;
            r_bad_cnt   <= 32'd0;
            r_idle_cnt  <= 32'd0;
            r_run       <= 8'd0;
            r_link_ok   <= 1'b0;
        end else begin
            r_frame_ok  <= w_good;
            r_frame_bad <= w_bad;
            if (w_good && r_good_cnt != 32'hFFFFFFFF)
                r_good_cnt <= r_good_cnt + 32'd1;
            if (w_bad && r_bad_cnt != 32'hFFFFFFFF)
                r_bad_cnt <= r_bad_cnt + 32'd1;
            if (gmii_rx_dv)
                r_idle_cnt <= 32'd0;
            else if (r_idle_cnt != c_timeout)
                r_idle_cnt <= r_idle_cnt + 32'd1;
            if (w_bad || w_seq_mis || w_timeout) begin
                r_run     <= 8'd0;
                r_link_ok <= 1'b0;
            end else if (w_good) begin
                if (r_run != c_lock)
                    r_run <= r_run + 8'd1;
                if (r_run + 8'd1 >= c_lock)
                    r_link_ok <= 1'b1;
            end
        end
    end

    assign frame_ok  = r_frame_ok;
    assign frame_bad = r_frame_bad;
    assign good_cnt  = r_good_cnt;
    assign bad_cnt   = r_bad_cnt;
    assign link_ok   = r_link_ok;

endmodule
`default_nettype wire

// File: tb/tb_pcspma_frame_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_pcspma_frame_checker
// Brief   : Directed self-checking bench for pcspma_frame_checker.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pcspma_frame_checker;

    localparam int PL  = 46;
    localparam int TMO = 1000;

    logic        userclk = 1'b0;
    logic        sys_reset_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        frame_ok;
    logic        frame_bad;
    logic        seq_err;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic [31:0] seq_err_cnt;
    logic        link_ok;

    always #4 userclk = ~userclk;

    pcspma_frame_checker #(
        .PAYLOAD_LEN    (PL),
        .LOCK_FRAMES    (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .userclk     (userclk),
        .sys_reset_n (sys_reset_n),
        .gmii_rxd    (gmii_rxd),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rx_er  (gmii_rx_er),
        .frame_ok    (frame_ok),
        .frame_bad   (frame_bad),
        .seq_err     (seq_err),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt),
        .seq_err_cnt (seq_err_cnt),
        .link_ok     (link_ok)
    );

`ifdef PCSPMA_CHK_SEQ_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int n_ok     = 0;
    int n_bad    = 0;
    logic [7:0] fb [0:1599];
    int fb_len;

    always @(negedge userclk) begin
        if (frame_ok === 1'b1)  n_ok++;
        if (frame_bad === 1'b1) n_bad++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_flags"}, {28'd0, frame_ok, frame_bad, seq_err, link_ok}, 32'd0);
        check_eq({tag, "_good_cnt"}, good_cnt, 32'd0);
        check_eq({tag, "_bad_cnt"}, bad_cnt, 32'd0);
        check_eq({tag, "_seq_err_cnt"}, seq_err_cnt, 32'd0);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // npre preamble bytes; len_adj -1 drops the last FCS byte, +1 appends one.
    task automatic build_frame(input logic [31:0] seq, input int npre, input int len_adj, input bit flip);
        logic [31:0] crc;
        int n;
        int hdr;
        n = 0;
        for (int i = 0; i < npre; i++) begin fb[n] = 8'h55; n++; end
        fb[n] = 8'hD5; n++;
        hdr = n;
        for (int i = 0; i < 6; i++) begin fb[n] = 8'hFF; n++; end
        for (int i = 0; i < 6; i++) begin
            fb[n] = (i == 0) ? 8'h02 : ((i == 5) ? 8'h01 : 8'h00);
            n++;
        end
        fb[n] = 8'h88; n++;
        fb[n] = 8'hB5; n++;
        fb[n] = seq[31:24]; n++;
        fb[n] = seq[23:16]; n++;
        fb[n] = seq[15:8];  n++;
        fb[n] = seq[7:0];   n++;
        for (int i = 0; i < PL; i++) begin fb[n] = seq[7:0] + 8'(i); n++; end
        crc = 32'hFFFFFFFF;
        for (int i = hdr; i < n; i++) crc = crc_upd(crc, fb[i]);
        crc = ~crc;
        fb[n] = crc[7:0];   n++;
        fb[n] = crc[15:8];  n++;
        fb[n] = crc[23:16]; n++;
        fb[n] = crc[31:24]; n++;
        if (flip) fb[n-1] = fb[n-1] ^ 8'h01;
        fb[n] = 8'h00;
        fb_len = n + len_adj;
    endtask

    // exp_v = {frame_ok, frame_bad, seq_err} expected in the verdict cycle.
    task automatic send_frame(input string tag, input int er_idx, input int rst_idx,
                              input logic [2:0] exp_v, input int gap);
        for (int i = 0; i < fb_len; i++) begin
            @(negedge userclk);
            if (i == rst_idx + 1) sys_reset_n = 1'b1;
            gmii_rxd   = fb[i];
            gmii_rx_dv = 1'b1;
            gmii_rx_er = (i == er_idx);
            if (i == rst_idx) begin
                sys_reset_n = 1'b0;
                #1;
                check_zero({tag, "_midreset"});
            end
        end
        @(negedge userclk);
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        @(negedge userclk);
        check_eq({tag, "_verdict"}, {29'd0, frame_ok, frame_bad, seq_err}, {29'd0, exp_v});
        repeat (gap - 1) @(negedge userclk);
    endtask

    task automatic do_reset();
        @(negedge userclk);
        sys_reset_n = 1'b0;
        gmii_rx_dv  = 1'b0;
        gmii_rx_er  = 1'b0;
        gmii_rxd    = 8'h00;
        repeat (3) @(negedge userclk);
        sys_reset_n = 1'b1;
        @(negedge userclk);
    endtask

    initial begin
        int ok0;
        int bad0;
        sys_reset_n = 1'b0;
        gmii_rx_dv  = 1'b0;
        gmii_rx_er  = 1'b0;
        gmii_rxd    = 8'h00;
        do_reset();
        check_zero("reset");

        // Ten good frames; lock on the fourth.
        ok0 = n_ok; bad0 = n_bad;
        for (int s = 0; s < 10; s++) begin
            build_frame(32'(s), 7, 0, 1'b0);
            send_frame($sformatf("good%0d", s), -1, -1, 3'b100, 12);
            check_eq($sformatf("link_after_good%0d", s), {31'd0, link_ok}, {31'd0, (s >= 3)});
        end
        check_eq("t1_good_cnt", good_cnt, 32'd10);
        check_eq("t1_bad_cnt", bad_cnt, 32'd0);
        check_eq("t1_ok_pulses", 32'(n_ok - ok0), 32'd10);
        check_eq("t1_bad_pulses", 32'(n_bad - bad0), 32'd0);

        // FCS bit error drops the link; four more good frames relock it.
        build_frame(32'd10, 7, 0, 1'b1);
        send_frame("fcs_flip", -1, -1, 3'b010, 12);
        check_eq("fcs_flip_link", {31'd0, link_ok}, 32'd0);
        check_eq("fcs_flip_bad_cnt", bad_cnt, 32'd1);
        for (int s = 11; s < 15; s++) begin
            build_frame(32'(s), 7, 0, 1'b0);
            send_frame($sformatf("relock%0d", s), -1, -1, 3'b100, 12);
            check_eq($sformatf("link_relock%0d", s), {31'd0, link_ok}, {31'd0, (s == 14)});
        end
        check_eq("t2_good_cnt", good_cnt, 32'd14);

        // Sequence gap 21 -> 23.
        do_reset();
        build_frame(32'd20, 7, 0, 1'b0); send_frame("seq20", -1, -1, 3'b100, 12);
        build_frame(32'd21, 7, 0, 1'b0); send_frame("seq21", -1, -1, 3'b100, 12);
        build_frame(32'd23, 7, 0, 1'b0); send_frame("seq23", -1, -1, {2'b10, SEQ_ON}, 12);
        check_eq("t3_seq_err_cnt", seq_err_cnt, {31'd0, SEQ_ON});
        check_eq("t3_good_cnt", good_cnt, 32'd3);
        check_eq("t3_link", {31'd0, link_ok}, 32'd0);

        // rx_er, short, long, over-long preamble, then a 1-byte preamble.
        do_reset();
        ok0 = n_ok;
        build_frame(32'd30, 7, 0, 1'b0);  send_frame("rx_er", 8 + 18 + 5, -1, 3'b010, 12);
        build_frame(32'd31, 7, -1, 1'b0); send_frame("short", -1, -1, 3'b010, 12);
        build_frame(32'd32, 7, 1, 1'b0);  send_frame("long", -1, -1, 3'b010, 12);
        check_eq("t4_bad_cnt", bad_cnt, 32'd3);
        check_eq("t4_ok_pulses", 32'(n_ok - ok0), 32'd0);
        build_frame(32'd33, 8, 0, 1'b0);  send_frame("pre8", -1, -1, 3'b010, 12);
        build_frame(32'd34, 1, 0, 1'b0);  send_frame("pre1", -1, -1, 3'b100, 12);
        check_eq("t4_bad_cnt_final", bad_cnt, 32'd4);
        check_eq("t4_good_cnt_final", good_cnt, 32'd1);

        // Idle timeout after lock, then resync with an arbitrary SEQ.
        do_reset();
        for (int s = 40; s < 44; s++) begin
            build_frame(32'(s), 7, 0, 1'b0);
            send_frame($sformatf("tmo_lock%0d", s), -1, -1, 3'b100, (s == 43) ? 1 : 12);
        end
        check_eq("tmo_locked", {31'd0, link_ok}, 32'd1);
        repeat (TMO - 2) @(negedge userclk);
        check_eq("tmo_999", {31'd0, link_ok}, 32'd1);
        @(negedge userclk);
        check_eq("tmo_1000", {31'd0, link_ok}, 32'd0);
        build_frame(32'd99, 7, 0, 1'b0);
        send_frame("resync", -1, -1, 3'b100, 12);
        check_eq("resync_seq_err_cnt", seq_err_cnt, 32'd0);

        // Reset mid-payload; the remainder is a bad frame start.
        do_reset();
        build_frame(32'd50, 7, 0, 1'b0);   send_frame("pre_rst", -1, -1, 3'b100, 12);
        build_frame(32'h100, 7, 0, 1'b0); send_frame("abort", -1, 8 + 18 + 10, 3'b010, 12);
        check_eq("abort_good_cnt", good_cnt, 32'd0);
        check_eq("abort_bad_cnt", bad_cnt, 32'd1);
        build_frame(32'h101, 7, 0, 1'b0); send_frame("post_rst", -1, -1, 3'b100, 12);
        check_eq("post_rst_good_cnt", good_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
